// File: rtl/bus_sync_rx_ctrl_pkg.sv
// Shared types and constants for the toggle-handshake CDC receive controller.
package bus_sync_rx_ctrl_pkg;

    localparam int unsigned SYNC_STAGES_MIN = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    // Baseline build has a single-entry buffer, so FULL aliases ONE.
    localparam state_t ST_FULL = ST_ONE;

    function automatic logic holds_word(input state_t s);
        return s != ST_EMPTY;
    endfunction

endpackage

// File: rtl/bus_sync_rx_ctrl_if.sv
// Source-side toggle handshake plus local valid/ready stream of the CDC receiver.
interface bus_sync_rx_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req_tgl;
    logic [WIDTH-1:0] data_in;
    logic             ack_tgl;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    // master: source + consumer side; slave: the receive controller
    modport master (
        output req_tgl, data_in, dout_ready,
        input  ack_tgl, dout, dout_valid
    );

    modport slave (
        input  req_tgl, data_in, dout_ready,
        output ack_tgl, dout, dout_valid
    );
endinterface

// File: rtl/tgl_sync_arst.sv
// N-flop synchroniser chain with asynchronous active-low reset to a programmable level.
module tgl_sync_arst #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned STAGES   = 2,
    parameter bit          NRST_VAL = 1'b0
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                chain[i] <= {WIDTH{NRST_VAL}};
            end
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/bus_sync_rx_ctrl.sv
// Receive side of a toggle-handshake multi-bit CDC: sync REQ, capture data, return ACK, stream out.
// Define BUS_SYNC_RX_SKID_EN for a two-entry buffer that acks on accept instead of on consumption.
module bus_sync_rx_ctrl
    import bus_sync_rx_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          NRST_VAL    = 1'b0
) (
    input  logic               clk,
    input  logic               nrst,
    bus_sync_rx_ctrl_if.slave  bus
);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync_stages
        $error("bus_sync_rx_ctrl: SYNC_STAGES must be >= %0d", SYNC_STAGES_MIN);
    end

    logic             req_s;
    logic             req_prev;
    logic             req_evt_c;
    logic             hs_c;
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;
    logic             ack_q;
    state_t           state_q;
    state_t           state_d;
    logic             accept_c;
    logic             load_in_c;
    logic             ack_c;

    tgl_sync_arst #(
        .WIDTH    (1),
        .STAGES   (SYNC_STAGES),
        .NRST_VAL (NRST_VAL)
    ) u_req_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (bus.req_tgl),
        .q    (req_s)
    );

    // A pending event persists until accepted, which is what stalls the source.
    assign req_evt_c = req_s ^ req_prev;
    assign hs_c      = dout_valid_q & bus.dout_ready;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state_q <= ST_EMPTY;
        else       state_q <= state_d;
    end

`ifdef BUS_SYNC_RX_SKID_EN
    logic [WIDTH-1:0] skid_q;
    logic             load_skid_c;
    logic             shift_skid_c;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (req_evt_c) state_d = ST_ONE;
            ST_ONE: begin
                if (req_evt_c && !hs_c)      state_d = ST_TWO;
                else if (!req_evt_c && hs_c) state_d = ST_EMPTY;
            end
            ST_TWO:   if (hs_c && !req_evt_c) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        accept_c     = 1'b0;
        load_in_c    = 1'b0;
        load_skid_c  = 1'b0;
        shift_skid_c = 1'b0;
        case (state_q)
            ST_EMPTY: if (req_evt_c) begin
                accept_c  = 1'b1;
                load_in_c = 1'b1;
            end
            ST_ONE: if (req_evt_c) begin
                accept_c    = 1'b1;
                load_in_c   = hs_c;
                load_skid_c = !hs_c;
            end
            // Full: a new word is taken only when the consumer frees a slot.
            ST_TWO: if (hs_c) begin
                shift_skid_c = 1'b1;
                accept_c     = req_evt_c;
                load_skid_c  = req_evt_c;
            end
            default: ;
        endcase
        ack_c = accept_c;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            skid_q <= '0;
            dout_q <= '0;
        end else begin
            if (load_skid_c)       skid_q <= bus.data_in;
            if (shift_skid_c)      dout_q <= skid_q;
            else if (load_in_c)    dout_q <= bus.data_in;
        end
    end
`else
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (req_evt_c) state_d = ST_FULL;
            ST_FULL:  if (hs_c)      state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // ACK only after consumption so the source sees full backpressure.
    always_comb begin
        accept_c  = 1'b0;
        load_in_c = 1'b0;
        ack_c     = 1'b0;
        case (state_q)
            ST_EMPTY: if (req_evt_c) begin
                accept_c  = 1'b1;
                load_in_c = 1'b1;
            end
            ST_FULL:  ack_c = hs_c;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)          dout_q <= '0;
        else if (load_in_c) dout_q <= bus.data_in;
    end
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            req_prev     <= NRST_VAL;
            dout_valid_q <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            if (accept_c) req_prev <= req_s;
            if (ack_c)    ack_q    <= ~ack_q;
            dout_valid_q <= holds_word(state_d);
        end
    end

    assign bus.ack_tgl    = ack_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_bus_sync_rx_ctrl.sv
// Directed bench for bus_sync_rx_ctrl; skid scenarios run when BUS_SYNC_RX_SKID_EN is defined.
module tb_bus_sync_rx_ctrl;

    localparam int unsigned WIDTH       = 8;
    localparam int unsigned SYNC_STAGES = 2;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic exp_ack  = 1'b0;
    logic [WIDTH-1:0] rx_q [$];

    always #5 clk = ~clk;

    bus_sync_rx_ctrl_if #(.WIDTH(WIDTH)) bus ();

    bus_sync_rx_ctrl #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .NRST_VAL    (1'b0)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w);
        bus.data_in = w;
        bus.req_tgl = ~bus.req_tgl;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        bus.req_tgl = 1'b0;
        bus.data_in = '0;
        bus.dout_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b want 0", bus.dout_valid);
        end
        checks++;
        if (bus.dout !== 8'h00) begin
            failures++; $display("FAIL reset_dout: got %h want 00", bus.dout);
        end
        checks++;
        if (bus.ack_tgl !== 1'b0) begin
            failures++; $display("FAIL reset_ack: got %b want 0", bus.ack_tgl);
        end
        nrst = 1'b1;
        exp_ack = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_single_transfer();
        send_word(8'hA5);
        for (int e = 1; e <= int'(SYNC_STAGES) + 1; e++) begin
            tick();
            checks++;
            if (e <= int'(SYNC_STAGES)) begin
                if (bus.dout_valid !== 1'b0) begin
                    failures++; $display("FAIL single_early_valid edge %0d: got %b want 0", e, bus.dout_valid);
                end
            end else begin
                if (bus.dout_valid !== 1'b1 || bus.dout !== 8'hA5) begin
                    failures++;
                    $display("FAIL single_latency: got valid=%b dout=%h want valid=1 dout=a5", bus.dout_valid, bus.dout);
                end
            end
        end
`ifdef BUS_SYNC_RX_SKID_EN
        exp_ack = ~exp_ack;
`endif
        checks++;
        if (bus.ack_tgl !== exp_ack) begin
            failures++; $display("FAIL single_ack: got %b want %b", bus.ack_tgl, exp_ack);
        end
    endtask

    task automatic test_backpressure();
        bus.dout_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (bus.dout !== 8'hA5 || bus.dout_valid !== 1'b1 || bus.ack_tgl !== exp_ack) begin
                failures++;
                $display("FAIL backpressure cycle %0d: got dout=%h valid=%b ack=%b want a5 1 %b",
                         c, bus.dout, bus.dout_valid, bus.ack_tgl, exp_ack);
            end
        end
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
`ifndef BUS_SYNC_RX_SKID_EN
        exp_ack = ~exp_ack;
`endif
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            failures++; $display("FAIL consume_valid: got %b want 0", bus.dout_valid);
        end
        checks++;
        if (bus.ack_tgl !== exp_ack) begin
            failures++; $display("FAIL consume_ack: got %b want %b", bus.ack_tgl, exp_ack);
        end
    endtask

    task automatic test_stream();
        int acks = 0;
        rx_q.delete();
        bus.dout_ready = 1'b0;
        fork
            begin : source
                for (int w = 0; w < 16; w++) begin
                    logic prev;
                    prev = bus.ack_tgl;
                    send_word(8'(w));
                    for (int c = 0; c < 400 && bus.ack_tgl === prev; c++) tick();
                    if (bus.ack_tgl !== prev) acks++;
                end
            end
            begin : consumer
                int cyc = 0;
                while (rx_q.size() < 16 && cyc < 4000) begin
                    tick();
                    cyc++;
                    bus.dout_ready = 1'($urandom_range(0, 1));
                    if (bus.dout_ready && bus.dout_valid) rx_q.push_back(bus.dout);
                end
            end
        join
        tick();
        bus.dout_ready = 1'b0;
        repeat (5) tick();
        checks++;
        if (acks != 16) begin
            failures++; $display("FAIL stream_ack_edges: got %0d want 16", acks);
        end
        checks++;
        if (rx_q.size() != 16) begin
            failures++; $display("FAIL stream_count: got %0d want 16", rx_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < 16; i++) begin
            checks++;
            if (rx_q[i] !== 8'(i)) begin
                failures++; $display("FAIL stream_word %0d: got %h want %h", i, rx_q[i], 8'(i));
            end
        end
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            failures++; $display("FAIL stream_idle_valid: got %b want 0", bus.dout_valid);
        end
    endtask

    task automatic test_reset_full();
        bus.dout_ready = 1'b0;
        send_word(8'h3C);
        for (int c = 0; c < 20 && bus.dout_valid !== 1'b1; c++) tick();
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h3C) begin
            failures++; $display("FAIL rst_full_setup: got valid=%b dout=%h want 1 3c", bus.dout_valid, bus.dout);
        end
        #2;
        nrst = 1'b0;
        bus.req_tgl = 1'b0;
        bus.data_in = '0;
        #1;
        checks++;
        if (bus.dout !== 8'h00 || bus.dout_valid !== 1'b0 || bus.ack_tgl !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: got dout=%h valid=%b ack=%b want 00 0 0", bus.dout, bus.dout_valid, bus.ack_tgl);
        end
        repeat (2) tick();
        nrst = 1'b1;
        exp_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (bus.dout_valid !== 1'b0 || bus.ack_tgl !== 1'b0) begin
                failures++;
                $display("FAIL rst_release cycle %0d: got valid=%b ack=%b want 0 0", c, bus.dout_valid, bus.ack_tgl);
            end
        end
    endtask

`ifdef BUS_SYNC_RX_SKID_EN
    task automatic test_skid_fill();
        logic [WIDTH-1:0] words [3];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        rx_q.delete();
        bus.dout_ready = 1'b0;
        for (int w = 0; w < 2; w++) begin
            send_word(words[w]);
            for (int c = 0; c < 40 && bus.ack_tgl === exp_ack; c++) tick();
            exp_ack = ~exp_ack;
            checks++;
            if (bus.ack_tgl !== exp_ack) begin
                failures++; $display("FAIL skid_ack word %0d: got %b want %b", w, bus.ack_tgl, exp_ack);
            end
        end
        send_word(words[2]);
        repeat (10) tick();
        checks++;
        if (bus.ack_tgl !== exp_ack || bus.dout_valid !== 1'b1 || bus.dout !== 8'h11) begin
            failures++;
            $display("FAIL skid_pending: got ack=%b valid=%b dout=%h want %b 1 11",
                     bus.ack_tgl, bus.dout_valid, bus.dout, exp_ack);
        end
        bus.dout_ready = 1'b1;
        for (int c = 0; c < 50 && rx_q.size() < 3; c++) begin
            if (bus.dout_valid) rx_q.push_back(bus.dout);
            tick();
        end
        bus.dout_ready = 1'b0;
        exp_ack = ~exp_ack;
        repeat (3) tick();
        checks++;
        if (bus.ack_tgl !== exp_ack || bus.dout_valid !== 1'b0) begin
            failures++; $display("FAIL skid_drain: got ack=%b valid=%b want %b 0", bus.ack_tgl, bus.dout_valid, exp_ack);
        end
        checks++;
        if (rx_q.size() != 3) begin
            failures++; $display("FAIL skid_count: got %0d want 3", rx_q.size());
        end
        for (int i = 0; i < rx_q.size() && i < 3; i++) begin
            checks++;
            if (rx_q[i] !== words[i]) begin
                failures++; $display("FAIL skid_order %0d: got %h want %h", i, rx_q[i], words[i]);
            end
        end
    endtask

    task automatic test_skid_same_cycle();
        bus.dout_ready = 1'b0;
        send_word(8'h44);
        for (int c = 0; c < 20 && bus.dout_valid !== 1'b1; c++) tick();
        exp_ack = ~exp_ack;
        checks++;
        if (bus.dout !== 8'h44 || bus.ack_tgl !== exp_ack) begin
            failures++; $display("FAIL same_setup: got dout=%h ack=%b want 44 %b", bus.dout, bus.ack_tgl, exp_ack);
        end
        send_word(8'h55);
        repeat (SYNC_STAGES) tick();
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        exp_ack = ~exp_ack;
        checks++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 8'h55 || bus.ack_tgl !== exp_ack) begin
            failures++;
            $display("FAIL same_cycle: got valid=%b dout=%h ack=%b want 1 55 %b",
                     bus.dout_valid, bus.dout, bus.ack_tgl, exp_ack);
        end
        bus.dout_ready = 1'b1;
        tick();
        bus.dout_ready = 1'b0;
        checks++;
        if (bus.dout_valid !== 1'b0) begin
            failures++; $display("FAIL same_drain: got %b want 0", bus.dout_valid);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_transfer();
        test_backpressure();
        test_stream();
        test_reset_full();
`ifdef BUS_SYNC_RX_SKID_EN
        test_skid_fill();
        test_skid_same_cycle();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
